calculate_core: RTL and testbench
=================================

# calculate_core

Front-end and arithmetic core of the six-digit keypad calculator. It derives the keypad-scan and display-refresh clocks from the board clock and encodes a 16-key active-low push-button pad into a 5-bit extended-BCD strobe/code. It also computes the signed 32-bit result of the operand/operator pair supplied by the sequencing FSM. It sits between the board pins and the calculator control FSM and segment driver.

## Interface
- SW_DIV_LOG2, default 21: sw_clk = clock_50m / 2^SW_DIV_LOG2.
- FND_DIV_LOG2, default 17: fnd_clk = clock_50m / 2^FND_DIV_LOG2; must be < SW_DIV_LOG2.
- clock_50m  in  1  board clock; the only clock, all flops on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pb  in  16  keypad buttons, active-low (0 = pressed).
- operand1  in  32  signed first operand (two's complement).
- operand2  in  32  signed second operand.
- operator  in  3  operator code.
- sw_clk  out  1  divided scan clock, 50 % duty.
- fnd_clk  out  1  divided display clock, 50 % duty.
- eBCD  out  5  [4] key-press strobe, [3:0] key code.
- ans  out  32  signed result or error code.

## Operation
- Divider: free-running SW_DIV_LOG2-bit up-counter `cnt`, wraps to 0.
  - sw_clk = cnt[SW_DIV_LOG2-1].
  - fnd_clk = cnt[FND_DIV_LOG2-1].
  - sw_tick = single-cycle enable on the cycle cnt[SW_DIV_LOG2-2:0] is all-ones while cnt[SW_DIV_LOG2-1] = 0, i.e. the clock_50m cycle before sw_clk rises.
  - All keypad and calculate registers update only on sw_tick.
- Key map, pb bit -> code:
  - 0→1, 1→2, 2→3, 3→A (÷/%).
  - 4→4, 5→5, 6→6, 7→B (×).
  - 8→7, 9→8, 10→9, 11→C (+/−).
  - 12→D (reserved), 13→0, 14→E (ans), 15→F (=).
- Keypad encoding, per sw_tick:
  - Register `pressed` = any bit of pb low.
  - Rising edge of `pressed` (previous sample all released, current sample ≥1 key low): eBCD[3:0] ← code of the lowest-index low bit; eBCD[4] ← 1.
  - Next sw_tick: eBCD[4] ← 0; eBCD[3:0] holds its last value.
  - A held key produces exactly one strobe, with no auto-repeat.
  - Additional keys pressed while one is held are ignored until all keys are released.
- Calculate, per sw_tick, ans ← f(operand1, operand2, operator), signed:
  - 0 EQU: operand1.
  - 1 TIMES: operand1 × operand2, with 64-bit intermediate.
  - 2 DIV: quotient truncated toward zero.
  - 3 PLUS: operand1 + operand2.
  - 4 MINUS: operand1 − operand2.
  - 5 MOD: remainder, sign follows operand1.
  - 6, 7: error.
- Error code 32'h00EE_0000 is output for:
  - DIV or MOD with operand2 = 0.
  - operator 6 or 7.
  - any exact result outside −99 999 … 999 999 (display range: 6 digits positive, 5 digits + sign negative); overflow is evaluated on the 64-bit exact value.

## Timing
- Reset (asynchronous): cnt = 0, sw_clk = 0, fnd_clk = 0, eBCD = 5'b0, key-history = released, ans = 0.
- Outputs are valid from the first clock after rst deasserts.
- Reset asserted mid-strobe clears eBCD[4] immediately.
- A key held across reset release is treated as already held, so no strobe is issued until it is released and pressed again.
- Keypad latency:
  - Strobe asserts on the first sw_tick where the press is sampled.
  - Strobe stays high for exactly one sw_clk period (2^SW_DIV_LOG2 clock_50m cycles).
  - A press shorter than one sw_clk period may be missed; this is accepted as debounce.
- Calculate latency: one sw_tick. Inputs sampled at sw_tick, ans stable for the following sw_clk period. No handshake.
- Counter wrap produces no glitch on sw_clk or fnd_clk.

## Test plan
Run with SW_DIV_LOG2 = 4 and FND_DIV_LOG2 = 2.
- Divider: release rst and run 64 clocks → sw_clk toggles every 8 cycles and fnd_clk every 2 cycles; both are 0 in reset.
- Keypad walk: pb = ~(1<<i) for i = 0..15, each held 5 sw periods then released 3 sw periods → one strobe per press with codes 1,2,3,A,4,5,6,B,7,8,9,C,D,0,E,F.
- Keypad overlap: hold bit 13 and add bit 2 → single strobe with code 0. Release all, then press bit 2 → code 3.
- Arithmetic, op1 = 10, op2 = 101:
  - ops 3/4/1/2/5 → 111, −91, 1010, 0, 10.
  - op1 = −10, op2 = 101 → 91, −111, −1010, 0, −10.
  - op1 = −10, op2 = −101 → −111, 91, 1010, 0, −10.
- Range, op1 = 100000, op2 = −500: ops 3/4/1/2/5 → 99500, 100500, 00EE_0000, −200, 0.
- Zero divisor, op1 = 1023, op2 = 0: ops 3/4/1/2/5 → 1023, 1023, 0, 00EE_0000, 00EE_0000. Operator 6 → 00EE_0000. Assert rst → ans = 0 immediately.

Source files
------------

// File: rtl/calculate_core.sv
// calculate_core: front end and arithmetic core of the six-digit keypad calculator.
//   clock_50m : board clock. All flops update on its rising edge.
//   rst       : asynchronous, active-high reset.
//   pb[15:0]  : keypad buttons, active-low.
//   operand1/operand2 : signed 32-bit operands from the control FSM.
//   operator  : operation code (0 EQU, 1 TIMES, 2 DIV, 3 PLUS, 4 MINUS, 5 MOD).
//   sw_clk    : scan clock = clock_50m / 2^SW_DIV_LOG2, 50 % duty.
//   fnd_clk   : display clock = clock_50m / 2^FND_DIV_LOG2, 50 % duty.
//   eBCD[4]   : key-press strobe, one sw_clk period long.
//   eBCD[3:0] : extended-BCD key code.
//   ans       : signed result, or 32'h00EE_0000 on error or out-of-range.
module calculate_core #(
  parameter int SW_DIV_LOG2  = 21,
  parameter int FND_DIV_LOG2 = 17
) (
  input  logic        clock_50m,
  input  logic        rst,
  input  logic [15:0] pb,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  operator,
  output logic        sw_clk,
  output logic        fnd_clk,
  output logic [4:0]  eBCD,
  output logic [31:0] ans
);

  typedef enum logic [2:0] {
    OP_EQU   = 3'd0,
    OP_TIMES = 3'd1,
    OP_DIV   = 3'd2,
    OP_PLUS  = 3'd3,
    OP_MINUS = 3'd4,
    OP_MOD   = 3'd5
  } op_e;

  localparam logic [31:0] ERR_CODE = 32'h00EE_0000;

  // pb bit index -> key code
  localparam logic [3:0] KEY_CODE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hD, 4'h0, 4'hE, 4'hF
  };

  logic [SW_DIV_LOG2-1:0] cnt;
  logic                   sw_tick;
  logic                   pressed;
  logic                   primed;
  logic                   any_low;
  logic [3:0]             low_idx;
  logic                   found;
  logic signed [63:0]     a64;
  logic signed [63:0]     b64;
  logic signed [63:0]     exact;
  logic                   err;
  logic [31:0]            next_ans;

  // Outputs taken straight from counter flops, so they cannot glitch.
  assign sw_clk  = cnt[SW_DIV_LOG2-1];
  assign fnd_clk = cnt[FND_DIV_LOG2-1];
  // Cycle before sw_clk rises: register updates coincide with its rising edge.
  assign sw_tick = (cnt[SW_DIV_LOG2-2:0] == '1) && !cnt[SW_DIV_LOG2-1];

  // Lowest-index pressed key wins.
  always_comb begin
    any_low = ~&pb;
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!pb[i] && !found) begin
        low_idx = 4'(i);
        found   = 1'b1;
      end
    end
  end

  // Exact arithmetic on 64-bit sign-extended operands; range check on the exact value.
  always_comb begin
    a64   = {{32{operand1[31]}}, operand1};
    b64   = {{32{operand2[31]}}, operand2};
    exact = '0;
    err   = 1'b0;
    case (op_e'(operator))
      OP_EQU:   exact = a64;
      OP_TIMES: exact = a64 * b64;
      OP_DIV:   if (b64 == 0) err = 1'b1; else exact = a64 / b64;
      OP_PLUS:  exact = a64 + b64;
      OP_MINUS: exact = a64 - b64;
      OP_MOD:   if (b64 == 0) err = 1'b1; else exact = a64 % b64;
      default:  err = 1'b1;
    endcase
    if (exact > 64'sd999999 || exact < -64'sd99999)
      err = 1'b1;
    next_ans = err ? ERR_CODE : exact[31:0];
  end

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pressed <= 1'b0;
      primed  <= 1'b0;
      eBCD    <= '0;
      ans     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (sw_tick) begin
        // The first tick after reset only loads key history, so a key held
        // across reset release is not reported.
        primed  <= 1'b1;
        pressed <= any_low;
        if (primed && any_low && !pressed)
          eBCD <= {1'b1, KEY_CODE[low_idx]};
        else
          eBCD[4] <= 1'b0;
        ans <= next_ans;
      end
    end
  end

endmodule

// File: tb/tb_calculate_core.sv
module tb_calculate_core;

  localparam logic [31:0] ERR = 32'h00EE_0000;

  logic        clock_50m;
  logic        rst;
  logic [15:0] pb;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operator;
  logic        sw_clk;
  logic        fnd_clk;
  logic [4:0]  eBCD;
  logic [31:0] ans;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  kq [$];   // expected key codes
  logic [31:0] aq [$];   // expected ans values

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] e;
  } vec_t;
  vec_t vt [$];

  calculate_core #(.SW_DIV_LOG2(4), .FND_DIV_LOG2(2)) dut (
    .clock_50m(clock_50m),
    .rst(rst),
    .pb(pb),
    .operand1(operand1),
    .operand2(operand2),
    .operator(operator),
    .sw_clk(sw_clk),
    .fnd_clk(fnd_clk),
    .eBCD(eBCD),
    .ans(ans)
  );

  initial clock_50m = 1'b0;
  always #5 clock_50m = ~clock_50m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void add(input int a, input int b, input int op, input int e);
    vt.push_back('{32'(a), 32'(b), 3'(op), 32'(e)});
  endfunction

  task automatic wait_sw(input int n);
    repeat (n * 16) @(posedge clock_50m);
    #1;
  endtask

  task automatic wait_sw_rise(output bit ok);
    logic prev;
    prev = sw_clk;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock_50m);
      #1;
      if (sw_clk && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = sw_clk;
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    bit ok;
    logic [31:0] e;
    operand1 = v.a;
    operand2 = v.b;
    operator = v.op;
    aq.push_back(v.e);
    wait_sw_rise(ok);
    e = aq.pop_front();
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL arith_timeout[%0d] got=none exp=%0h", idx, e);
    end else begin
      check($sformatf("arith[%0d] op=%0d a=%0d b=%0d", idx, v.op, $signed(v.a), $signed(v.b)), ans, e);
    end
  endtask

  task automatic press(input int idx, input logic [3:0] code);
    kq.push_back(code);
    pb = ~(16'h1 << idx);
    wait_sw(5);
    pb = '1;
    wait_sw(3);
  endtask

  // Key strobe monitor: code and width checked against the expected queue.
  initial begin
    logic prev;
    int   width;
    logic [3:0] e;
    prev  = 1'b0;
    width = 0;
    forever begin
      @(posedge clock_50m);
      #1;
      if (rst) begin
        prev  = 1'b0;
        width = 0;
      end else begin
        if (eBCD[4] && !prev) begin
          if (kq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL key_unexpected got=%0h exp=none", eBCD[3:0]);
          end else begin
            e = kq.pop_front();
            check("key_code", 32'(eBCD[3:0]), 32'(e));
          end
          width = 1;
        end else if (eBCD[4]) begin
          width++;
        end else if (prev) begin
          check("strobe_width", 32'(width), 32'd16);
        end
        prev = eBCD[4];
      end
    end
  end

  initial begin
    bit ok;
    rst      = 1'b1;
    pb       = '1;
    operand1 = '0;
    operand2 = '0;
    operator = '0;
    repeat (3) @(posedge clock_50m);
    #1;
    check("rst_sw_clk", 32'(sw_clk), 32'd0);
    check("rst_fnd_clk", 32'(fnd_clk), 32'd0);
    check("rst_eBCD", 32'(eBCD), 32'd0);
    check("rst_ans", ans, 32'd0);

    // Divider: cnt counts from 0 after release.
    @(negedge clock_50m);
    rst = 1'b0;
    for (int m = 1; m <= 64; m++) begin
      @(posedge clock_50m);
      #1;
      check($sformatf("sw_clk[%0d]", m), 32'(sw_clk), 32'((m >> 3) & 1));
      check($sformatf("fnd_clk[%0d]", m), 32'(fnd_clk), 32'((m >> 1) & 1));
    end

    // Keypad walk.
    begin
      logic [3:0] codes [16];
      codes = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hD, 4'h0, 4'hE, 4'hF};
      for (int i = 0; i < 16; i++) press(i, codes[i]);
    end
    check("walk_drained", 32'(kq.size()), 32'd0);

    // Overlap: second key while first held is ignored.
    kq.push_back(4'h0);
    pb = ~(16'h1 << 13);
    wait_sw(2);
    pb = ~((16'h1 << 13) | (16'h1 << 2));
    wait_sw(3);
    pb = '1;
    wait_sw(3);
    press(2, 4'h3);
    check("overlap_drained", 32'(kq.size()), 32'd0);

    // Reset mid-strobe, key held across reset release.
    kq.push_back(4'h5);
    pb = ~(16'h1 << 5);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock_50m);
      #1;
      if (eBCD[4]) begin
        ok = 1'b1;
        break;
      end
    end
    check("strobe_seen", 32'(ok), 32'd1);
    @(negedge clock_50m);
    rst = 1'b1;
    #1;
    check("rst_mid_strobe", 32'(eBCD), 32'd0);
    @(negedge clock_50m);
    rst = 1'b0;
    wait_sw(4);
    check("held_no_strobe", 32'(eBCD[4]), 32'd0);
    pb = '1;
    wait_sw(3);
    press(5, 4'h5);
    check("rst_seq_drained", 32'(kq.size()), 32'd0);

    // Arithmetic vectors.
    add(10, 101, 3, 111);      add(10, 101, 4, -91);     add(10, 101, 1, 1010);
    add(10, 101, 2, 0);        add(10, 101, 5, 10);
    add(-10, 101, 3, 91);      add(-10, 101, 4, -111);   add(-10, 101, 1, -1010);
    add(-10, 101, 2, 0);       add(-10, 101, 5, -10);
    add(-10, -101, 3, -111);   add(-10, -101, 4, 91);    add(-10, -101, 1, 1010);
    add(-10, -101, 2, 0);      add(-10, -101, 5, -10);
    add(100000, -500, 3, 99500);  add(100000, -500, 4, 100500);
    add(100000, -500, 1, int'(ERR)); add(100000, -500, 2, -200);
    add(100000, -500, 5, 0);
    add(999999, 0, 3, 999999); add(999999, 1, 3, int'(ERR));
    add(-99999, 7, 0, -99999); add(-99999, 1, 4, int'(ERR));
    add(1023, 0, 0, 1023);
    add(1023, 0, 3, 1023);     add(1023, 0, 4, 1023);    add(1023, 0, 1, 0);
    add(1023, 0, 2, int'(ERR)); add(1023, 0, 5, int'(ERR));
    add(1023, 0, 7, int'(ERR)); add(1023, 0, 6, int'(ERR));
    foreach (vt[i]) apply(i, vt[i]);

    @(negedge clock_50m);
    rst = 1'b1;
    #1;
    check("rst_ans_async", ans, 32'd0);
    check("ans_queue_drained", 32'(aq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
